// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous-read memory between N_REQ requesters.
//   Round-robin arbitration, with an optional lock that keeps ownership across
//   consecutive accesses for an atomic read-modify-write. A lock is held for
//   at most MAX_LOCK cycles in total, counting the cycle that won it.
//   A granted read returns one cycle later on the requester's rvalid bit,
//   with rdata taken from the memory read port.
//
// Ports
//   clock_i          system clock, rising edge
//   rst_i            synchronous reset, active-high
//   req_i   [N]      access request per requester, held until granted
//   lock_i  [N]      keep ownership after this grant
//   we_i    [N]      1 = write, 0 = read
//   addr_i  [N*A]    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata_i [N*D]    packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt_o   [N]      one-hot, access presented to memory this cycle
//   rvalid_o[N]      one-hot, rdata_o valid for this requester's read
//   rdata_o [D]      read data (memory output during rvalid, else last read)
//   mem_address_o    memory address
//   mem_wr_en_o      memory write enable
//   mem_data_in_o    memory write data
//   mem_data_out_i   memory read data, valid one cycle after the read address
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clock_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          lock_i,
    input  logic [N_REQ-1:0]          we_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         mem_address_o,
    output logic                      mem_wr_en_o,
    output logic [DATA_W-1:0]         mem_data_in_o,
    input  logic [DATA_W-1:0]         mem_data_out_i
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    // Number of cycles the owner has already held the lock before this one.
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                arb_found_s;
    logic [PTR_W-1:0]    arb_idx_s;
    logic                any_gnt_s;
    logic [PTR_W-1:0]    sel_s;
    logic [N_REQ-1:0]    gnt_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    // (base + k) mod N_REQ for base < N_REQ and k < N_REQ.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W:0]   k);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + k;
        if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Round-robin scan: first requester at or after ptr_q, wrapping.
    always_comb begin
        logic [PTR_W-1:0] idx;
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = wrap_add(ptr_q, (PTR_W+1)'(k));
            if (!arb_found_s && req_i[idx]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = idx;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Grant selection; while locked only the owner can be served.
    always_comb begin
        any_gnt_s = 1'b0;
        sel_s     = '0;
        gnt_s     = '0;
        if (rst_i) begin
            any_gnt_s = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            any_gnt_s = req_i[owner_q];
            sel_s     = owner_q;
        end else begin
            any_gnt_s = arb_found_s;
            sel_s     = arb_idx_s;
        end
        if (any_gnt_s) begin
            gnt_s[sel_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Memory bus mux and output masking during reset.
    always_comb begin
        gnt_o         = gnt_s;
        mem_address_o = '0;
        mem_data_in_o = '0;
        mem_wr_en_o   = 1'b0;
        if (any_gnt_s) begin
            mem_address_o = addr_i[int'(sel_s)*ADDR_W +: ADDR_W];
            mem_data_in_o = wdata_i[int'(sel_s)*DATA_W +: DATA_W];
            mem_wr_en_o   = we_i[sel_s];
        end else begin
            mem_wr_en_o   = 1'b0;
        end
        if (rst_i) begin
            rvalid_o = '0;
            rdata_o  = '0;
        end else if (|rvalid_q) begin
            rvalid_o = rvalid_q;
            rdata_o  = mem_data_out_i;
        end else begin
            rvalid_o = '0;
            rdata_o  = rdata_q;
        end
    end

    // Next-state logic for arbitration state, pointer, lock owner and counter.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc_s  = lock_cnt_q + CNT_W'(1);
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        case (state_q)
            ST_ARB: begin
                if (arb_found_s && lock_i[arb_idx_s]) begin
                    state_d    = ST_LOCKED;
                    owner_d    = arb_idx_s;
                    lock_cnt_d = CNT_W'(1);
                end else if (arb_found_s) begin
                    ptr_d = wrap_add(arb_idx_s, (PTR_W+1)'(1));
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_LOCKED: begin
                // Counts every locked cycle, granted or not; the ex-owner
                // goes to the back of the queue on release.
                lock_cnt_d = cnt_inc_s;
                if (!lock_i[owner_q] || (cnt_inc_s == CNT_W'(MAX_LOCK))) begin
                    state_d    = ST_ARB;
                    ptr_d      = wrap_add(owner_q, (PTR_W+1)'(1));
                    lock_cnt_d = '0;
                end else begin
                    state_d    = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_ARB;
                lock_cnt_d = '0;
            end
        endcase
        if (any_gnt_s && !we_i[sel_s]) begin
            rvalid_d = gnt_s;
        end else begin
            rvalid_d = '0;
        end
        if (|rvalid_q) begin
            rdata_d = mem_data_out_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int ML = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_address;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            mem_init;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clock_i        (clk),
        .rst_i          (rst),
        .req_i          (req),
        .lock_i         (lock),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .mem_address_o  (mem_address),
        .mem_wr_en_o    (mem_wr_en),
        .mem_data_in_o  (mem_data_in),
        .mem_data_out_i (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with synchronous read (read-first).
    logic [DW-1:0] tb_mem [0:2047];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) tb_mem[i] <= '0;
            mem_data_out <= '0;
        end else begin
            if (mem_wr_en) tb_mem[mem_address] <= mem_data_in;
            mem_data_out <= tb_mem[mem_address];
        end
    end

    // ---------------- reference model ----------------
    bit            m_locked;
    int            m_owner, m_held, m_ptr, m_rv_who;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_mem [0:2047];

    function automatic int model_winner();
        if (rst) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int w;
        logic [N-1:0] eg;
        w  = model_winner();
        eg = (w >= 0) ? N'(1) << w : '0;
        chk("rnd_gnt", 32'(gnt), 32'(eg));
        chk("rnd_wr_en", 32'(mem_wr_en), (w >= 0) ? 32'(we[w]) : 32'd0);
        chk("rnd_addr", 32'(mem_address), (w >= 0) ? 32'(addr[w*AW +: AW]) : 32'd0);
        if (w >= 0 && we[w]) chk("rnd_wdata", 32'(mem_data_in), 32'(wdata[w*DW +: DW]));
        if (rst) begin
            chk("rnd_rst_rvalid", 32'(rvalid), 32'd0);
            chk("rnd_rst_rdata", 32'(rdata), 32'd0);
        end else if (m_rv_who >= 0) begin
            chk("rnd_rvalid", 32'(rvalid), 32'(N'(1) << m_rv_who));
            chk("rnd_rdata", 32'(rdata), 32'(m_rv_data));
        end else begin
            chk("rnd_rvalid", 32'(rvalid), 32'd0);
        end
    endtask

    // Advance the model using the current inputs, then the clock.
    task automatic tick();
        int w;
        logic [AW-1:0] a;
        w = model_winner();
        if (rst) begin
            m_locked = 1'b0; m_owner = 0; m_held = 0; m_ptr = 0; m_rv_who = -1;
        end else begin
            m_rv_who = -1;
            if (w >= 0) begin
                a = addr[w*AW +: AW];
                if (we[w]) m_mem[a] = wdata[w*DW +: DW];
                else begin
                    m_rv_who  = w;
                    m_rv_data = m_mem[a];
                end
            end
            if (!m_locked) begin
                if (w >= 0 && lock[w]) begin
                    m_locked = 1'b1; m_owner = w; m_held = 1;
                end else if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                end
            end else begin
                m_held++;
                if (!lock[m_owner] || m_held == ML) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          r;
        logic [N-1:0]  rq, lk, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  eg;
        logic          ew;
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        logic          cd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic r, logic [2:0] rq, logic [2:0] lk, logic [2:0] w,
                                 logic [10:0] a, logic [15:0] d, logic [2:0] eg, logic ew,
                                 logic [2:0] ev, logic [15:0] ed, logic cd);
        vec_t v;
        v.r = r; v.rq = rq; v.lk = lk; v.w = w; v.a = a; v.d = d;
        v.eg = eg; v.ew = ew; v.ev = ev; v.ed = ed; v.cd = cd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        rst = v.r; req = v.rq; lock = v.lk; we = v.w;
        addr = {N{v.a}}; wdata = {N{v.d}};
        #2;
        chk({tag, "_gnt"}, 32'(gnt), 32'(v.eg));
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'(v.ew));
        chk({tag, "_addr"}, 32'(mem_address), (v.eg != '0) ? 32'(v.a) : 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'(v.ev));
        if (v.cd) chk({tag, "_rdata"}, 32'(rdata), 32'(v.ed));
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        mem_init = 1'b1;
        m_locked = 1'b0; m_owner = 0; m_held = 0; m_ptr = 0; m_rv_who = -1; m_rv_data = '0;
        for (int i = 0; i < 2048; i++) m_mem[i] = '0;
        @(negedge clk);
        tick();
        mem_init = 1'b0;

        // reset, round-robin, write/read, RMW lock, lock timeout
        tbl.push_back(mkv(1, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b000, 0, 3'b000, 16'h0000, 1));
        tbl.push_back(mkv(1, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b000, 0, 3'b000, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b001, 0, 3'b000, 16'h0000, 0));
        tbl.push_back(mkv(0, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b010, 0, 3'b001, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b100, 0, 3'b010, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b111, 3'b000, 3'b000, 11'd5,  16'h0000, 3'b001, 0, 3'b100, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b001, 3'b000, 3'b001, 11'd15, 16'h0680, 3'b001, 1, 3'b001, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b001, 3'b000, 3'b000, 11'd15, 16'h0000, 3'b001, 0, 3'b000, 16'h0000, 0));
        tbl.push_back(mkv(0, 3'b000, 3'b000, 3'b000, 11'd15, 16'h0000, 3'b000, 0, 3'b001, 16'h0680, 1));
        tbl.push_back(mkv(0, 3'b111, 3'b010, 3'b000, 11'd2,  16'h0000, 3'b010, 0, 3'b000, 16'h0000, 0));
        tbl.push_back(mkv(0, 3'b111, 3'b000, 3'b010, 11'd2,  16'h1234, 3'b010, 1, 3'b010, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b000, 3'b000, 11'd2,  16'h0000, 3'b100, 0, 3'b000, 16'h0000, 0));
        tbl.push_back(mkv(0, 3'b000, 3'b000, 3'b000, 11'd2,  16'h0000, 3'b000, 0, 3'b100, 16'h1234, 1));
        tbl.push_back(mkv(0, 3'b010, 3'b000, 3'b000, 11'd7,  16'h0000, 3'b010, 0, 3'b000, 16'h0000, 0));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b100, 0, 3'b010, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b100, 0, 3'b100, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b100, 0, 3'b100, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b100, 0, 3'b100, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b001, 0, 3'b100, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b101, 3'b100, 3'b000, 11'd7,  16'h0000, 3'b100, 0, 3'b001, 16'h0000, 1));
        tbl.push_back(mkv(0, 3'b000, 3'b000, 3'b000, 11'd7,  16'h0000, 3'b000, 0, 3'b100, 16'h0000, 1));
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // reset one cycle after a locked read grant: no rvalid, no write
        run_vec(mkv(0, 3'b010, 3'b010, 3'b000, 11'd15, 16'h0000, 3'b010, 0, 3'b000, 16'h0000, 0), "rstlk0");
        run_vec(mkv(1, 3'b010, 3'b010, 3'b010, 11'd15, 16'hBEEF, 3'b000, 0, 3'b000, 16'h0000, 1), "rstlk1");
        run_vec(mkv(0, 3'b110, 3'b000, 3'b000, 11'd15, 16'h0000, 3'b010, 0, 3'b000, 16'h0000, 0), "rstlk2");
        run_vec(mkv(0, 3'b000, 3'b000, 3'b000, 11'd15, 16'h0000, 3'b000, 0, 3'b010, 16'h0680, 1), "rstlk3");

        // idle owner keeps others waiting until the lock drops
        run_vec(mkv(0, 3'b100, 3'b100, 3'b000, 11'd9, 16'h0000, 3'b100, 0, 3'b000, 16'h0000, 0), "idle0");
        run_vec(mkv(0, 3'b011, 3'b100, 3'b000, 11'd9, 16'h0000, 3'b000, 0, 3'b100, 16'h0000, 0), "idle1");
        run_vec(mkv(0, 3'b011, 3'b000, 3'b000, 11'd9, 16'h0000, 3'b000, 0, 3'b000, 16'h0000, 0), "idle2");
        run_vec(mkv(0, 3'b011, 3'b000, 3'b000, 11'd9, 16'h0000, 3'b001, 0, 3'b000, 16'h0000, 0), "idle3");

        // randomized traffic against the reference model
        rst = 1'b1; req = '0; lock = '0; we = '0;
        #2 check_model();
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r1, r2;
            r1   = N'($urandom);
            r2   = N'($urandom);
            rst  = ($urandom_range(0, 99) == 0);
            req  = N'($urandom);
            lock = ((c % 400) < 200) ? ~(r1 & r2) : (r1 & r2);
            we   = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
                wdata[i*DW +: DW] = DW'($urandom);
            end
            #2 check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
